// File: rtl/instr_encoder.sv
// MIPS field-set encoder feeding a small FIFO that streams words into
// instruction memory at an auto-incrementing (loadable) word address.
module instr_encoder #(
  parameter int DEPTH     = 4,
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [3:0]        in_kind_i,
  input  logic [4:0]        in_rs_i,
  input  logic [4:0]        in_rt_i,
  input  logic [4:0]        in_rd_i,
  input  logic [4:0]        in_shamt_i,
  input  logic [5:0]        in_funct_i,
  input  logic [15:0]       in_imm_i,
  input  logic              load_en_i,
  input  logic [ADDR_W-1:0] load_addr_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_data_o,
  input  logic              mem_ready_i,
  output logic              err_o,
  output logic [15:0]       count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_OCC = (PTR_W+1)'(DEPTH);

  logic [31:0]       fifoMem [DEPTH];
  logic [PTR_W-1:0]  wrPtrReg, rdPtrReg;
  logic [PTR_W:0]    occReg;
  logic [ADDR_W-1:0] addrReg;
  logic [15:0]       countReg;
  logic              errReg;

  logic        kindLegal;
  logic [5:0]  opcode;
  logic [31:0] encWord;
  logic        accept, push, pop;

  always_comb begin
    kindLegal = 1'b1;
    opcode    = 6'b000000;
    case (in_kind_i)
      4'd0: opcode = 6'b000000;
      4'd1: opcode = 6'b001000;
      4'd2: opcode = 6'b001010;
      4'd3: opcode = 6'b100011;
      4'd4: opcode = 6'b101011;
      4'd5: opcode = 6'b000100;
      4'd6: opcode = 6'b000101;
      4'd7: opcode = 6'b000001;
      4'd8: opcode = 6'b000111;
      default: kindLegal = 1'b0;
    endcase
    if (in_kind_i == 4'd0)
      encWord = {opcode, in_rs_i, in_rt_i, in_rd_i, in_shamt_i, in_funct_i};
    else
      encWord = {opcode, in_rs_i, in_rt_i, in_imm_i};
  end

  // Ready is judged on current occupancy only; a same-cycle pop never frees a slot early.
  assign in_ready_o = (occReg != FULL_OCC) && !rst_i;
  assign mem_we_o   = (occReg != '0) && !rst_i;
  assign mem_addr_o = addrReg;
  assign mem_data_o = fifoMem[rdPtrReg];
  assign err_o      = errReg;
  assign count_o    = countReg;

  assign accept = in_valid_i && in_ready_o;
  assign push   = accept && kindLegal;
  assign pop    = mem_we_o && mem_ready_i;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : gStore
      always_ff @(posedge clk_i) begin
        if (push && (wrPtrReg == PTR_W'(gi)))
          fifoMem[gi] <= encWord;
      end
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wrPtrReg <= '0;
      rdPtrReg <= '0;
      occReg   <= '0;
      addrReg  <= ADDR_W'(BASE_ADDR);
      countReg <= '0;
      errReg   <= 1'b0;
    end else begin
      if (push) wrPtrReg <= wrPtrReg + PTR_W'(1);
      if (pop) begin
        rdPtrReg <= rdPtrReg + PTR_W'(1);
        countReg <= countReg + 16'd1;
      end
      case ({push, pop})
        2'b10:   occReg <= occReg + (PTR_W+1)'(1);
        2'b01:   occReg <= occReg - (PTR_W+1)'(1);
        default: occReg <= occReg;
      endcase
      // A load wins over the increment; the popping word already used the old address.
      if (load_en_i)  addrReg <= load_addr_i;
      else if (pop)   addrReg <= addrReg + ADDR_W'(1);
      if (accept && !kindLegal) errReg <= 1'b1;
    end
  end

endmodule
